pc_fetch_sequencer: RTL and testbench

Controls the program counter and instruction-fetch handshake at the front of the pipelined RISC-V core. It holds the architectural fetch PC, issues fetch requests to instruction memory and advances by 4 on each accepted fetch. It applies hazard-unit stalls and EX-stage branch/jump redirects, and emits the IF/ID flush pulse. It sits between the hazard unit and EX branch logic on one side and instruction memory and the IF/ID register on the other.

---
 rtl/pc_fetch_sequencer.sv | 116 +++++++++++
 tb/tb_pc_fetch_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// PC / instruction-fetch sequencer: holds the fetch PC, drives the imem
// handshake, applies stalls and EX redirects, and emits the IF/ID flush.
// Optional macro PC_MISALIGN_CHECK_EN: a misaligned redirect target
// raises sticky misalign_err and parks the sequencer in HALT.
// Ports: clk, reset_n (async, active-low); stall, redirect_valid,
// redirect_target from hazard/EX; imem_req, imem_addr, imem_ready to
// instruction memory; pc_out, pc_valid, flush to IF/ID; misalign_err.
module pc_fetch_sequencer #(
    parameter int unsigned      XLEN     = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            flush,
    output logic            misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic            flush_q, flush_d;
    logic            err_q, err_d;
    logic            accept;

    // Fetch is suppressed whenever the PC is about to change or hold.
    assign imem_req  = (state_q == FETCH) && !stall && !redirect_valid;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        valid_d  = 1'b0;
        flush_d  = 1'b0;
        err_d    = err_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    flush_d = 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
                    if (redirect_target[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d = redirect_target;
                    end
`else
                    // Low bits dropped: targets are always word aligned.
                    pc_d = redirect_target & ALIGN_MASK;
`endif
                end else if (accept) begin
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                end
            end
            default: begin
                // HALT: frozen until reset.
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            flush_q  <= flush_d;
            err_q    <= err_d;
        end
    end

    assign pc_out   = pc_out_q;
    assign pc_valid = valid_q;
    assign flush    = flush_q;

`ifdef PC_MISALIGN_CHECK_EN
    assign misalign_err = err_q;
`else
    logic unused_err;
    assign unused_err   = err_q;
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: vector table plus hand-written
// reset, async-reset and PC-wrap sequences.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [63:0] pc_out;
    logic        pc_valid;
    logic        flush;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .pc_out          (pc_out),
        .pc_valid        (pc_valid),
        .flush           (flush),
        .misalign_err    (misalign_err)
    );

    typedef struct {
        logic        stall;
        logic        rv;
        logic [63:0] tgt;
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] po;
        logic        fl;
        logic        err;
    } vec_t;

    vec_t vec [17];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic rv,
                         input logic [63:0] t, input logic r);
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        imem_ready      = r;
    endtask

    function automatic vec_t mk(input logic s, input logic rv,
                                input logic [63:0] t, input logic r,
                                input logic q, input logic [63:0] a,
                                input logic v, input logic [63:0] p,
                                input logic f, input logic e);
        vec_t x;
        x.stall = s; x.rv = rv; x.tgt = t; x.rdy = r;
        x.req = q; x.addr = a; x.valid = v; x.po = p;
        x.fl = f; x.err = e;
        return x;
    endfunction

    initial begin
        //          st rv tgt      rdy req addr     v po      fl err
        vec[0]  = mk(0, 0, 64'h0,   1,  0, 64'h0,   0, 64'h0,  0, 0);
        vec[1]  = mk(0, 0, 64'h0,   1,  1, 64'h0,   0, 64'h0,  0, 0);
        vec[2]  = mk(0, 0, 64'h0,   1,  1, 64'h4,   1, 64'h0,  0, 0);
        vec[3]  = mk(0, 0, 64'h0,   1,  1, 64'h8,   1, 64'h4,  0, 0);
        vec[4]  = mk(0, 0, 64'h0,   1,  1, 64'hC,   1, 64'h8,  0, 0);
        vec[5]  = mk(1, 0, 64'h0,   1,  0, 64'h10,  1, 64'hC,  0, 0);
        vec[6]  = mk(1, 0, 64'h0,   1,  0, 64'h10,  0, 64'hC,  0, 0);
        vec[7]  = mk(1, 0, 64'h0,   1,  0, 64'h10,  0, 64'hC,  0, 0);
        vec[8]  = mk(0, 0, 64'h0,   1,  1, 64'h10,  0, 64'hC,  0, 0);
        vec[9]  = mk(0, 0, 64'h0,   0,  1, 64'h14,  1, 64'h10, 0, 0);
        vec[10] = mk(0, 0, 64'h0,   1,  1, 64'h14,  0, 64'h10, 0, 0);
        vec[11] = mk(1, 1, 64'h40,  1,  0, 64'h18,  1, 64'h14, 0, 0);
        vec[12] = mk(1, 1, 64'h200, 1,  0, 64'h40,  0, 64'h14, 1, 0);
        vec[13] = mk(0, 0, 64'h0,   1,  1, 64'h200, 0, 64'h14, 1, 0);
        vec[14] = mk(0, 1, 64'h202, 1,  0, 64'h204, 1, 64'h200, 0, 0);
`ifdef PC_MISALIGN_CHECK_EN
        vec[15] = mk(0, 0, 64'h0,   1,  0, 64'h204, 0, 64'h200, 1, 1);
        vec[16] = mk(0, 0, 64'h0,   1,  0, 64'h204, 0, 64'h200, 0, 1);
`else
        vec[15] = mk(0, 0, 64'h0,   1,  1, 64'h200, 0, 64'h200, 1, 0);
        vec[16] = mk(0, 0, 64'h0,   1,  1, 64'h204, 1, 64'h200, 0, 0);
`endif

        reset_n = 1'b0;
        drive(0, 0, 64'h0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req",   {63'h0, imem_req}, 64'h0);
        chk("rst_pcout", pc_out, 64'h0);
        chk("rst_valid", {63'h0, pc_valid}, 64'h0);
        chk("rst_flush", {63'h0, flush}, 64'h0);
        chk("rst_err",   {63'h0, misalign_err}, 64'h0);

        @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vec[i].stall, vec[i].rv, vec[i].tgt, vec[i].rdy);
            #1;
            chk($sformatf("v%0d_req", i), {63'h0, imem_req}, {63'h0, vec[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr, vec[i].addr);
            chk($sformatf("v%0d_valid", i), {63'h0, pc_valid}, {63'h0, vec[i].valid});
            chk($sformatf("v%0d_pcout", i), pc_out, vec[i].po);
            chk($sformatf("v%0d_flush", i), {63'h0, flush}, {63'h0, vec[i].fl});
            chk($sformatf("v%0d_err", i), {63'h0, misalign_err}, {63'h0, vec[i].err});
        end

        // Asynchronous reset mid-stream, between clock edges.
        drive(0, 0, 64'h0, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req",   {63'h0, imem_req}, 64'h0);
        chk("arst_addr",  imem_addr, 64'h0);
        chk("arst_pcout", pc_out, 64'h0);
        chk("arst_valid", {63'h0, pc_valid}, 64'h0);
        chk("arst_flush", {63'h0, flush}, 64'h0);
        chk("arst_err",   {63'h0, misalign_err}, 64'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk); #1;
        chk("boot_req", {63'h0, imem_req}, 64'h0);
        @(negedge clk); #1;
        chk("rs_req0",  {63'h0, imem_req}, 64'h1);
        chk("rs_addr0", imem_addr, 64'h0);
        @(negedge clk); #1;
        chk("rs_addr1",  imem_addr, 64'h4);
        chk("rs_valid1", {63'h0, pc_valid}, 64'h1);
        chk("rs_pcout1", pc_out, 64'h0);

        // Wrap of the top word address back to zero.
        @(negedge clk);
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
        @(negedge clk);
        drive(0, 0, 64'h0, 1);
        #1;
        chk("wr_addr",  imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_flush", {63'h0, flush}, 64'h1);
        chk("wr_req",   {63'h0, imem_req}, 64'h1);
        @(negedge clk); #1;
        chk("wr_addr0", imem_addr, 64'h0);
        chk("wr_pcout", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_valid", {63'h0, pc_valid}, 64'h1);
        chk("wr_err",   {63'h0, misalign_err}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
